// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the SDRAM bank-check scheduler and its helpers.
package jtsdram_pkg;

    localparam int unsigned PCW        = 8;
    localparam int unsigned SETTLE_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CHECK  = 3'd5,
        ST_END    = 3'd6
    } state_t;

    // Pass counter increment that sticks at all-ones.
    function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v);
        return (&v) ? v : v + PCW'(1);
    endfunction

endpackage

// File: rtl/jtsdram_bank_sched_if.sv
// Control/status and checker-array signals of the bank pass scheduler.
interface jtsdram_bank_sched_if
    import jtsdram_pkg::*;
#(
    parameter int unsigned BANKS = 4
) ();

    logic             go;
    logic             stop;
    logic             LVBL;
    logic [BANKS-1:0] en_mask;
    logic [BANKS-1:0] bank_done;
    logic [BANKS-1:0] bank_bad;
    logic [BANKS-1:0] bank_start;
    logic             slow;
    logic             busy;
    logic [PCW-1:0]   pass_cnt;
    logic [BANKS-1:0] bad_mask;
    logic             timeout;
    logic             finished;

    modport master (
        output go, stop, LVBL, en_mask, bank_done, bank_bad,
        input  bank_start, slow, busy, pass_cnt, bad_mask, timeout, finished
    );

    modport slave (
        input  go, stop, LVBL, en_mask, bank_done, bank_bad,
        output bank_start, slow, busy, pass_cnt, bad_mask, timeout, finished
    );

endinterface

// File: rtl/jtsdram_wdog.sv
// Clearable free-running watchdog counter; term_c is high while the count is all-ones.
module jtsdram_wdog #(
    parameter int unsigned W = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + W'(1);
    end

    assign term_c = &cnt;

endmodule

// File: rtl/jtsdram_bank_sched.sv
// Pass scheduler for the SDRAM bank checkers: start pulses, fast/slow alternation, done/bad/timeout collection.
// Build option JTSDRAM_SCHED_VBL_EN: each pass starts on an LVBL falling edge instead of straight after ARM.
module jtsdram_bank_sched
    import jtsdram_pkg::*;
#(
    parameter int unsigned BANKS  = 4,
    parameter int unsigned PASSES = 8,
    parameter int unsigned TOW    = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    jtsdram_bank_sched_if.slave bus
);

    localparam int unsigned SCW = 2;

    state_t           state;
    logic [BANKS-1:0] mask;
    logic             go_q;
    logic [SCW-1:0]   settle_cnt;
    logic             wd_term_c;
    logic             wd_clr_c;
    logic             wd_en_c;
    logic             go_rise_c;
    logic             all_done_c;
    logic             arm_go_c;
    logic             done_run_c;
    logic [PCW-1:0]   pass_nxt_c;

    assign go_rise_c  = bus.go & ~go_q;
    // Disabled banks count as done.
    assign all_done_c = &(bus.bank_done | ~mask);
    assign pass_nxt_c = sat_inc(bus.pass_cnt);
    assign done_run_c = bus.stop || ((PASSES != 0) && (pass_nxt_c == PCW'(PASSES)));
    assign wd_clr_c   = (state == ST_START);
    assign wd_en_c    = (state == ST_WAIT);

`ifdef JTSDRAM_SCHED_VBL_EN
    logic lvbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvbl_q <= 1'b1;
        else        lvbl_q <= bus.LVBL;
    end

    assign arm_go_c = lvbl_q & ~bus.LVBL;
`else
    logic unused_lvbl;

    assign unused_lvbl = bus.LVBL;
    assign arm_go_c    = 1'b1;
`endif

    jtsdram_wdog #(.W(TOW)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr_c),
        .en     (wd_en_c),
        .term_c (wd_term_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mask           <= '0;
            go_q           <= 1'b0;
            settle_cnt     <= '0;
            bus.bank_start <= '0;
            bus.slow       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.pass_cnt   <= '0;
            bus.bad_mask   <= '0;
            bus.timeout    <= 1'b0;
            bus.finished   <= 1'b0;
        end else begin
            go_q           <= bus.go;
            bus.bank_start <= '0;
            case (state)
                ST_IDLE: begin
                    if (go_rise_c) begin
                        mask         <= bus.en_mask;
                        bus.bad_mask <= '0;
                        bus.pass_cnt <= '0;
                        bus.timeout  <= 1'b0;
                        bus.finished <= 1'b0;
                        bus.slow     <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= (bus.en_mask == '0) ? ST_END : ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (arm_go_c) state <= ST_START;
                end
                ST_START: begin
                    bus.bank_start <= mask;
                    settle_cnt     <= '0;
                    state          <= ST_SETTLE;
                end
                // Give checkers time to drop the previous pass's done.
                ST_SETTLE: begin
                    if (settle_cnt == SCW'(SETTLE_CYC - 1)) state <= ST_WAIT;
                    else                                     settle_cnt <= settle_cnt + SCW'(1);
                end
                // Done takes priority over a watchdog expiry in the same cycle.
                ST_WAIT: begin
                    if (all_done_c) begin
                        state <= ST_CHECK;
                    end else if (wd_term_c) begin
                        bus.timeout  <= 1'b1;
                        bus.bad_mask <= bus.bad_mask | (mask & ~bus.bank_done);
                        state        <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    bus.bad_mask <= bus.bad_mask | (bus.bank_bad & mask);
                    bus.pass_cnt <= pass_nxt_c;
                    bus.slow     <= ~bus.slow;
                    state        <= done_run_c ? ST_END : ST_ARM;
                end
                ST_END: begin
                    bus.busy     <= 1'b0;
                    bus.finished <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_sched.sv
// Bench for jtsdram_bank_sched: two instances (PASSES=2/TOW=6 and PASSES=0/TOW=8) driven by behavioural bank checkers.
module tb_jtsdram_bank_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lvbl;
    logic       go_v   [2];
    logic       stop_v [2];
    logic [3:0] mask_v [2];

    int         dly [4];
    logic [3:0] hang;
    logic [3:0] bad_bank;
    int         bad_pass;

    logic [3:0] obs_start [2];
    logic [3:0] obs_bad   [2];
    logic [7:0] obs_pc    [2];
    logic       obs_slow  [2];
    logic       obs_busy  [2];
    logic       obs_to    [2];
    logic       obs_fin   [2];

    logic [3:0] st_q [2][$];
    logic       sl_q [2][$];
    int         last_st [2];
    int         to_dly  [2];
    logic       to_p    [2];

    int cyc = 0;
    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        lvbl = 1'b1;
        repeat (30) @(posedge clk);
        lvbl = 1'b0;
        repeat (4) @(posedge clk);
    end

    for (genvar d = 0; d < 2; d++) begin : g_dut
        jtsdram_bank_sched_if #(.BANKS(4)) ifc ();

        int         cnt [4];
        int         np  [4];
        logic [3:0] done_r;
        logic [3:0] bad_r;
        logic       go_p;

        assign ifc.go        = go_v[d];
        assign ifc.stop      = stop_v[d];
        assign ifc.LVBL      = lvbl;
        assign ifc.en_mask   = mask_v[d];
        assign ifc.bank_done = done_r;
        assign ifc.bank_bad  = bad_r;

        jtsdram_bank_sched #(
            .BANKS  (4),
            .PASSES ((d == 0) ? 2 : 0),
            .TOW    ((d == 0) ? 6 : 8)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );

        assign obs_start[d] = ifc.bank_start;
        assign obs_bad[d]   = ifc.bad_mask;
        assign obs_pc[d]    = ifc.pass_cnt;
        assign obs_slow[d]  = ifc.slow;
        assign obs_busy[d]  = ifc.busy;
        assign obs_to[d]    = ifc.timeout;
        assign obs_fin[d]   = ifc.finished;

        // Checker model: done dly cycles after its start pulse, bad only in the configured pass of the run.
        always @(posedge clk) begin
            go_p <= go_v[d];
            for (int b = 0; b < 4; b++) begin
                if (!rst_n) begin
                    cnt[b]    <= -1;
                    np[b]     <= 0;
                    done_r[b] <= 1'b0;
                    bad_r[b]  <= 1'b0;
                end else if (ifc.bank_start[b]) begin
                    cnt[b]    <= 0;
                    np[b]     <= np[b] + 1;
                    done_r[b] <= 1'b0;
                    bad_r[b]  <= 1'b0;
                end else begin
                    if (go_v[d] && !go_p) np[b] <= 0;
                    if (cnt[b] >= 0 && !hang[b]) begin
                        if (cnt[b] >= dly[b] - 1) begin
                            done_r[b] <= 1'b1;
                            bad_r[b]  <= bad_bank[b] && (np[b] == bad_pass);
                            cnt[b]    <= -1;
                        end else begin
                            cnt[b] <= cnt[b] + 1;
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (ifc.bank_start != 4'd0) begin
                st_q[d].push_back(ifc.bank_start);
                sl_q[d].push_back(ifc.slow);
                last_st[d] = cyc;
            end
            if (ifc.timeout && !to_p[d]) to_dly[d] = cyc - last_st[d];
            to_p[d] = ifc.timeout;
        end
    end

    task automatic start_run(input int d, input logic [3:0] m);
        @(posedge clk);
        #1;
        mask_v[d] = m;
        go_v[d]   = 1'b1;
        @(posedge clk);
        #1;
        go_v[d]   = 1'b0;
    endtask

    task automatic wait_fin(input int d, input string nm);
        int n = 0;
        while (!obs_fin[d] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (obs_fin[d] !== 1'b1) begin
            err++;
            $display("FAIL %s finished: got %b, need 1 within 5000 cycles", nm, obs_fin[d]);
        end
    endtask

    task automatic wait_starts(input int d, input int want, input string nm);
        int n = 0;
        while (st_q[d].size() < want && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (st_q[d].size() < want) begin
            err++;
            $display("FAIL %s start_wait: got %0d pulses, need %0d", nm, st_q[d].size(), want);
        end
    endtask

    // Expected end-of-run state from the pass count, mask and checker configuration.
    task automatic check_run(input int d, input int base, input logic [3:0] m, input int np, input string nm);
        logic [3:0] eb;
        logic       et;
        int         got_n;
        et = (np > 0) && ((hang & m) != 4'd0);
        eb = (np > 0) ? (hang & m) : 4'd0;
        if (bad_pass >= 1 && bad_pass <= np) eb = eb | (bad_bank & m & ~hang);
        got_n = st_q[d].size() - base;
        vec++;
        if (got_n != np) begin
            err++;
            $display("FAIL %s start_count: got %0d, need %0d", nm, got_n, np);
        end else begin
            for (int k = 0; k < np; k++) begin
                vec++;
                if (st_q[d][base+k] !== m) begin
                    err++;
                    $display("FAIL %s start_val[%0d]: got %h, need %h", nm, k, st_q[d][base+k], m);
                end
                vec++;
                if (sl_q[d][base+k] !== 1'(k % 2)) begin
                    err++;
                    $display("FAIL %s slow[%0d]: got %b, need %0d", nm, k, sl_q[d][base+k], k % 2);
                end
            end
        end
        vec++;
        if (obs_pc[d] !== 8'(np)) begin
            err++;
            $display("FAIL %s pass_cnt: got %0d, need %0d", nm, obs_pc[d], np);
        end
        vec++;
        if (obs_bad[d] !== eb) begin
            err++;
            $display("FAIL %s bad_mask: got %h, need %h", nm, obs_bad[d], eb);
        end
        vec++;
        if (obs_to[d] !== et) begin
            err++;
            $display("FAIL %s timeout: got %b, need %b", nm, obs_to[d], et);
        end
        vec++;
        if (obs_busy[d] !== 1'b0) begin
            err++;
            $display("FAIL %s busy: got %b, need 0", nm, obs_busy[d]);
        end
        vec++;
        if (obs_slow[d] !== 1'(np % 2)) begin
            err++;
            $display("FAIL %s final_slow: got %b, need %0d", nm, obs_slow[d], np % 2);
        end
    endtask

    task automatic set_checkers(input int lo, input int hi, input logic [3:0] h, input logic [3:0] bb, input int bp);
        for (int b = 0; b < 4; b++) dly[b] = $urandom_range(hi, lo);
        hang     = h;
        bad_bank = bb;
        bad_pass = bp;
    endtask

    task automatic check_idle_zero(input int d, input string nm);
        vec++;
        if ({obs_start[d], obs_bad[d], obs_pc[d], obs_slow[d], obs_busy[d], obs_to[d], obs_fin[d]} !== 20'd0) begin
            err++;
            $display("FAIL %s outputs: got start=%h bad=%h pc=%0d slow=%b busy=%b to=%b fin=%b, need all 0",
                     nm, obs_start[d], obs_bad[d], obs_pc[d], obs_slow[d], obs_busy[d], obs_to[d], obs_fin[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero(0, "reset_d0");
        check_idle_zero(1, "reset_d1");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_two_pass();
        int base = st_q[0].size();
        set_checkers(50, 50, 4'd0, 4'd0, 0);
        start_run(0, 4'hF);
        wait_fin(0, "two_pass");
        check_run(0, base, 4'hF, 2, "two_pass");
    endtask

    task automatic test_partial_mask();
        int base = st_q[0].size();
        set_checkers(5, 55, 4'b0010, 4'd0, 0);
        start_run(0, 4'b0101);
        wait_fin(0, "partial_mask");
        check_run(0, base, 4'b0101, 2, "partial_mask");
    endtask

    task automatic test_bad_pass1();
        int base = st_q[0].size();
        set_checkers(5, 55, 4'd0, 4'b0100, 1);
        start_run(0, 4'hF);
        wait_starts(0, base + 2, "bad_pass1");
        @(negedge clk);
        vec++;
        if (obs_bad[0] !== 4'b0100) begin
            err++;
            $display("FAIL bad_pass1 mid_pass2_bad: got %h, need 4", obs_bad[0]);
        end
        wait_fin(0, "bad_pass1");
        check_run(0, base, 4'hF, 2, "bad_pass1");
    endtask

    task automatic test_timeout();
        int base = st_q[0].size();
        set_checkers(5, 55, 4'b1000, 4'd0, 0);
        start_run(0, 4'hF);
        wait_fin(0, "timeout");
        check_run(0, base, 4'hF, 2, "timeout");
        // Two SETTLE cycles, then WAIT cycles 0..63, then the registered flag.
        vec++;
        if (to_dly[0] != 66) begin
            err++;
            $display("FAIL timeout latency: got %0d cycles after start, need 66", to_dly[0]);
        end
    endtask

    task automatic test_zero_mask();
        int base = st_q[0].size();
        start_run(0, 4'd0);
        wait_fin(0, "zero_mask");
        check_run(0, base, 4'd0, 0, "zero_mask");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int         base = st_q[0].size();
            logic [3:0] m    = 4'($urandom_range(15, 1));
            logic [3:0] h    = ($urandom_range(3, 0) == 0) ? 4'(1 << $urandom_range(3, 0)) : 4'd0;
            set_checkers(3, 55, h, 4'($urandom_range(15, 0)), $urandom_range(2, 0));
            start_run(0, m);
            wait_fin(0, "random");
            check_run(0, base, m, 2, "random");
        end
    endtask

    task automatic test_go_stop();
        int base = st_q[0].size();
        set_checkers(5, 40, 4'd0, 4'd0, 0);
        stop_v[0] = 1'b1;
        start_run(0, 4'hA);
        wait_fin(0, "go_stop");
        check_run(0, base, 4'hA, 1, "go_stop");
        stop_v[0] = 1'b0;
    endtask

    task automatic test_stop_passes0();
        int base = st_q[1].size();
        set_checkers(10, 40, 4'd0, 4'd0, 0);
        start_run(1, 4'hF);
        wait_starts(1, base + 5, "stop_p0");
        repeat (4) @(posedge clk);
        #1;
        stop_v[1] = 1'b1;
        go_v[1]   = 1'b1;
        @(posedge clk);
        #1 go_v[1] = 1'b0;
        wait_fin(1, "stop_p0");
        check_run(1, base, 4'hF, 5, "stop_p0");
        stop_v[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base = st_q[0].size();
        set_checkers(30, 30, 4'd0, 4'd0, 0);
        start_run(0, 4'hF);
        wait_starts(0, base + 2, "reset_mid");
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_zero(0, "reset_mid_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = st_q[0].size();
        start_run(0, 4'h7);
        wait_fin(0, "reset_mid_rerun");
        check_run(0, base, 4'h7, 2, "reset_mid_rerun");
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            go_v[d]   = 1'b0;
            stop_v[d] = 1'b0;
            mask_v[d] = 4'd0;
        end
        set_checkers(10, 10, 4'd0, 4'd0, 0);
        test_reset();
        test_two_pass();
        test_partial_mask();
        test_bad_pass1();
        test_timeout();
        test_zero_mask();
        test_random();
        test_go_stop();
        test_stop_passes0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: run still active at %0t, need completion", $time);
        $fatal(1);
    end

endmodule
